// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and constants for the unified memory port arbiter.
package rv_mem_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: watchdog counter; expired is high in the TIMEOUT-th enabled cycle after a clear.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d   = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between fetch (I) and load/store (D),
// one transaction at a time, D first, with a watchdog that forces completion and flags bus_err.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          bus_req,
    output logic          bus_we,
    output logic [3:0]    bus_be,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_err
);

    state_e        state_q;
    owner_e        owner_q;
    logic          we_q, bus_req_q, i_ready_q, d_ready_q, err_q;
    logic [3:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic          expired, fin_ok, tout, fin;
    logic [DW-1:0] fin_data;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (state_q == IDLE),
        .en      (state_q == ADDR || state_q == RESP),
        .expired (expired)
    );

    // A response arriving in the watchdog's last cycle still wins over the timeout.
    assign fin_ok   = (state_q == RESP) && bus_rvalid;
    assign tout     = expired && !fin_ok;
    assign fin      = fin_ok || tout;
    assign fin_data = (fin_ok && !we_q) ? bus_rdata : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_req_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_req) begin
                        owner_q   <= OWN_D;
                        we_q      <= d_we;
                        be_q      <= d_be;
                        addr_q    <= d_addr;
                        wdata_q   <= d_wdata;
                        bus_req_q <= 1'b1;
                        state_q   <= ADDR;
                    end else if (i_req) begin
                        owner_q   <= OWN_I;
                        we_q      <= 1'b0;
                        be_q      <= BE_FULL;
                        addr_q    <= i_addr;
                        wdata_q   <= '0;
                        bus_req_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP:    ;
                default: state_q <= IDLE;
            endcase
            // Completion (normal or forced) overrides the per-state transitions above.
            if (fin) begin
                state_q   <= DONE;
                bus_req_q <= 1'b0;
                if (owner_q == OWN_D) begin
                    d_rdata_q <= fin_data;
                    d_ready_q <= 1'b1;
                end else begin
                    i_rdata_q <= fin_data;
                    i_ready_q <= 1'b1;
                end
                if (tout) err_q <= 1'b1;
            end
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus randomized transactions against a latency/data model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_be;
    logic [DW-1:0] d_wdata, i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          bus_req, bus_we, bus_err;
    logic [3:0]    bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic          bus_gnt, bus_rvalid;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int i_cnt = 0;
    int d_cnt = 0;

    int            cfg_g = 0;
    int            cfg_r = 0;
    bit            cfg_drop = 1'b0;
    logic [DW-1:0] cfg_rdata = '0;
    bit            rsp_busy = 1'b0;
    bit            exp_err = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i_ready === 1'b1) i_cnt = i_cnt + 1;
        if (d_ready === 1'b1) d_cnt = d_cnt + 1;
    end

    // Bus slave: grants cfg_g cycles after seeing bus_req, answers cfg_r cycles after the grant cycle.
    initial begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                rsp_busy = 1'b1;
                repeat (cfg_g) @(negedge clk);
                bus_gnt = 1'b1;
                @(negedge clk);
                bus_gnt = 1'b0;
                if (!cfg_drop) begin
                    repeat (cfg_r) @(negedge clk);
                    bus_rvalid = 1'b1;
                    bus_rdata  = cfg_rdata;
                    @(negedge clk);
                    bus_rvalid = 1'b0;
                    bus_rdata  = $urandom;
                end
                rsp_busy = 1'b0;
            end
        end
    end

    // Cycles from request sampling to the ready pulse, straight from the timing rules.
    function automatic int exp_lat(input int g, input int r, input bit drop);
        return (!drop && g + r + 2 <= T) ? g + r + 3 : T + 1;
    endfunction

    task automatic run_txn(input bit is_d, input bit we, input logic [3:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int g, input int r, input bit drop, input logic [DW-1:0] rd_in,
                           output int lat, output logic [DW-1:0] rd,
                           output int bad_bus, output int req_cycles);
        logic [AW+DW+5:0] want;
        int start;
        cfg_g = g; cfg_r = r; cfg_drop = drop; cfg_rdata = rd_in;
        want = is_d ? {we, be, addr, wd} : {1'b0, 4'hF, addr, {DW{1'b0}}};
        @(negedge clk);
        start = cyc;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = -1; rd = 'x; bad_bus = 0; req_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                d_we = $urandom; d_be = $urandom; d_addr = $urandom; d_wdata = $urandom; i_addr = $urandom;
            end
            if (bus_req === 1'b1) begin
                req_cycles++;
                if ({bus_we, bus_be, bus_addr, bus_wdata} !== want) bad_bus++;
            end
            if ((is_d ? d_ready : i_ready) === 1'b1) begin
                lat = cyc - start;
                rd  = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 60 && rsp_busy; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        tests++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, i_ready, d_ready, i_rdata, d_rdata, bus_err} !== '0)
            begin fails++; $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wd=%h ir=%b dr=%b ird=%h drd=%h err=%b, want all 0",
                bus_req, bus_we, bus_be, bus_addr, bus_wdata, i_ready, d_ready, i_rdata, d_rdata, bus_err); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch();
        int lat, bad, rc, ic, dc;
        logic [DW-1:0] rd;
        ic = i_cnt; dc = d_cnt;
        run_txn(1'b0, 1'b0, 4'h0, 32'h1000_0000, '0, 0, 0, 1'b0, 32'h0000_0513, lat, rd, bad, rc);
        tests++; if (lat !== 3) begin fails++; $display("FAIL fetch_latency: got %0d want 3", lat); end
        tests++; if (rd !== 32'h0000_0513) begin fails++; $display("FAIL fetch_rdata: got %h want 00000513", rd); end
        tests++; if (bad !== 0 || rc !== 1) begin fails++; $display("FAIL fetch_bus: bad=%0d req_cycles=%0d want 0/1", bad, rc); end
        tests++; if (i_cnt - ic !== 1 || d_cnt - dc !== 0) begin fails++; $display("FAIL fetch_pulses: i=%0d d=%0d want 1/0", i_cnt - ic, d_cnt - dc); end
    endtask

    task automatic test_simultaneous();
        int d_at = -1, i_at = -1, ic, dc;
        logic [DW-1:0] drd, ird;
        cfg_g = 0; cfg_r = 0; cfg_drop = 1'b0; cfg_rdata = 32'hA5A5_1234;
        ic = i_cnt; dc = d_cnt;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++;
                if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000_0004, 32'hDEAD_BEEF})
                    begin fails++; $display("FAIL sim_d_bus: got req=%b we=%b be=%h addr=%h wd=%h", bus_req, bus_we, bus_be, bus_addr, bus_wdata); end
            end
            if (k == 5) begin
                tests++;
                if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0})
                    begin fails++; $display("FAIL sim_i_bus: got req=%b we=%b be=%h addr=%h wd=%h", bus_req, bus_we, bus_be, bus_addr, bus_wdata); end
            end
            if (d_ready === 1'b1) begin d_at = k; drd = d_rdata; d_req = 1'b0; end
            if (i_ready === 1'b1) begin i_at = k; ird = i_rdata; i_req = 1'b0; end
        end
        tests++; if (d_at !== 3 || i_at !== 7) begin fails++; $display("FAIL sim_order: d_ready@%0d i_ready@%0d want 3/7", d_at, i_at); end
        tests++; if (drd !== '0 || ird !== 32'hA5A5_1234) begin fails++; $display("FAIL sim_rdata: d=%h i=%h want 0/a5a51234", drd, ird); end
        tests++; if (i_cnt - ic !== 1 || d_cnt - dc !== 1) begin fails++; $display("FAIL sim_pulses: i=%0d d=%0d want 1/1", i_cnt - ic, d_cnt - dc); end
        @(negedge clk);
    endtask

    task automatic test_slow_bus();
        int lat, bad, rc, ic;
        logic [DW-1:0] rd;
        ic = i_cnt;
        run_txn(1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h1111_2222, 3, 4, 1'b0, 32'h7654_3210, lat, rd, bad, rc);
        tests++; if (lat !== 10) begin fails++; $display("FAIL slow_latency: got %0d want 10", lat); end
        tests++; if (rd !== 32'h7654_3210) begin fails++; $display("FAIL slow_rdata: got %h want 76543210", rd); end
        tests++; if (bad !== 0 || rc !== 4) begin fails++; $display("FAIL slow_bus_stable: bad=%0d req_cycles=%0d want 0/4", bad, rc); end
        tests++; if (i_cnt !== ic) begin fails++; $display("FAIL slow_i_ready: got %0d pulses want 0", i_cnt - ic); end
    endtask

    task automatic test_held();
        int at[$];
        logic req4, req5;
        cfg_g = 0; cfg_r = 0; cfg_drop = 1'b0; cfg_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_1000;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 4) req4 = bus_req;
            if (k == 5) req5 = bus_req;
            if (i_ready === 1'b1) begin
                at.push_back(k);
                if (at.size() == 3) i_req = 1'b0;
            end
        end
        tests++;
        if (at.size() !== 3 || at[0] !== 3 || at[1] !== 7 || at[2] !== 11)
            begin fails++; $display("FAIL held_pulses: got %0d pulses, %p want 3 at 3,7,11", at.size(), at); end
        tests++; if (req4 !== 1'b0 || req5 !== 1'b1) begin fails++; $display("FAIL held_reissue: bus_req c4=%b c5=%b want 0/1", req4, req5); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat, bad, rc, dc, ic;
        logic [DW-1:0] rd;
        run_txn(1'b1, 1'b0, 4'hF, 32'h4000_0000, '0, 0, 0, 1'b1, 32'hFFFF_FFFF, lat, rd, bad, rc);
        exp_err = 1'b1;
        tests++; if (lat !== T + 1) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", lat, T + 1); end
        tests++; if (rd !== '0) begin fails++; $display("FAIL timeout_rdata: got %h want 0", rd); end
        tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", bus_err); end
        dc = d_cnt; ic = i_cnt;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_CAFE; bus_gnt = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_gnt = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (d_cnt !== dc || i_cnt !== ic || d_rdata !== '0 || bus_req !== 1'b0)
            begin fails++; $display("FAIL late_rvalid: pulses d=%0d i=%0d d_rdata=%h bus_req=%b want 0/0/0/0", d_cnt - dc, i_cnt - ic, d_rdata, bus_req); end
        run_txn(1'b0, 1'b0, 4'h0, 32'h1000_0004, '0, 0, 0, 1'b0, 32'h0000_0013, lat, rd, bad, rc);
        tests++; if (lat !== 3 || rd !== 32'h0000_0013) begin fails++; $display("FAIL post_timeout_fetch: lat=%0d rd=%h want 3/00000013", lat, rd); end
        tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus_err); end
    endtask

    task automatic test_random();
        int lat, bad, rc, g, r, ic, dc;
        bit is_d, we;
        logic [DW-1:0] rd, rv, want;
        for (int n = 0; n < 24; n++) begin
            is_d = $urandom_range(0, 1);
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            g    = $urandom_range(0, 5);
            r    = $urandom_range(0, 12);
            rv   = $urandom;
            ic = i_cnt; dc = d_cnt;
            run_txn(is_d, we, 4'($urandom), $urandom, $urandom, g, r, 1'b0, rv, lat, rd, bad, rc);
            if (g + r + 2 > T) exp_err = 1'b1;
            want = (we || g + r + 2 > T) ? '0 : rv;
            tests++;
            if (lat !== exp_lat(g, r, 1'b0) || rd !== want || bad !== 0 || bus_err !== exp_err)
                begin fails++; $display("FAIL random[%0d]: d=%b we=%b g=%0d r=%0d lat=%0d/%0d rd=%h/%h bad_bus=%0d err=%b/%b",
                    n, is_d, we, g, r, lat, exp_lat(g, r, 1'b0), rd, want, bad, bus_err, exp_err); end
            tests++;
            if ((is_d ? d_cnt - dc : i_cnt - ic) !== 1 || (is_d ? i_cnt - ic : d_cnt - dc) !== 0)
                begin fails++; $display("FAIL random_pulses[%0d]: i=%0d d=%0d owner_d=%b", n, i_cnt - ic, d_cnt - dc, is_d); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bad, rc, ic, dc;
        logic [DW-1:0] rd;
        cfg_g = 0; cfg_r = 0; cfg_drop = 1'b1;
        ic = i_cnt; dc = d_cnt;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h5000_0000;
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        tests++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, i_ready, d_ready, i_rdata, d_rdata, bus_err} !== '0)
            begin fails++; $display("FAIL reset_mid_outputs: req=%b be=%h addr=%h ird=%h drd=%h err=%b want all 0",
                bus_req, bus_be, bus_addr, i_rdata, d_rdata, bus_err); end
        i_req = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (25) @(negedge clk);
        tests++; if (i_cnt !== ic || d_cnt !== dc) begin fails++; $display("FAIL reset_mid_no_ready: i=%0d d=%0d want 0/0", i_cnt - ic, d_cnt - dc); end
        run_txn(1'b0, 1'b0, 4'h0, 32'h1000_0100, '0, 0, 0, 1'b0, 32'h1234_5678, lat, rd, bad, rc);
        tests++; if (lat !== 3 || rd !== 32'h1234_5678) begin fails++; $display("FAIL reset_mid_refetch: lat=%0d rd=%h want 3/12345678", lat, rd); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_mid_err: got %b want 0", bus_err); end
    endtask

    initial begin
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_slow_bus();
        test_held();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
